// File: rtl/mul_share_arbiter.sv
// Round-robin share of one pipelined a*b multiplier; results tagged with requester id after LAT cycles.
// A response held by rsp_ready=0 freezes every stage and masks all req_ready bits.
module mul_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int N         = 16,
  parameter int R         = 8,
  parameter int PRECISION = 16,
  parameter int LAT       = 2,
  localparam int IDW      = $clog2(NREQ),
  localparam int BW       = R + PRECISION,
  localparam int PW       = N + R + PRECISION
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_a,
  input  logic [NREQ*BW-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [PW-1:0]      rsp_data,
  output logic               busy
);

  logic            w_stall;
  logic            w_acc;
  logic            w_gnt_any;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic [N-1:0]    w_sel_a;
  logic [BW-1:0]   w_sel_b;
  logic [PW-1:0]   w_prod1;

  logic [IDW-1:0]  r_ptr;
  logic [N-1:0]    r_a;
  logic [BW-1:0]   r_b;
  logic [LAT-1:0]  r_vld;
  logic [IDW-1:0]  r_id [LAT];
  logic [PW-1:0]   r_p  [LAT];
  logic [PW-1:0]   w_p  [LAT];

  assign w_stall = r_vld[LAT-1] & ~rsp_ready;

  // First valid requester at or above r_ptr, wrapping around.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    w_gnt     = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!w_gnt_any && req_valid[idx_w]) begin
        w_gnt[idx_w] = 1'b1;
        w_gnt_id     = idx_w;
        w_gnt_any    = 1'b1;
      end
    end
  end

  assign req_ready = w_gnt & {NREQ{~w_stall & rst_n}};
  assign w_acc     = w_gnt_any & ~w_stall;
  assign w_sel_a   = req_a[w_gnt_id*N +: N];
  assign w_sel_b   = req_b[w_gnt_id*BW +: BW];
  assign w_prod1   = PW'(r_a) * PW'(r_b);

  // w_p[s] is the product as seen at the output of stage s+1.
  always_comb begin
    w_p[0] = w_prod1;
    for (int s = 1; s < LAT; s++) begin
      w_p[s] = r_p[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_id[s] <= '0;
        r_p[s]  <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= w_acc;
      if (w_acc) begin
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_id[0] <= w_gnt_id;
        r_ptr   <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
      end
      for (int s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_id[s] <= r_id[s-1];
          r_p[s]  <= w_p[s-1];
        end
      end
    end
  end

  assign rsp_valid = r_vld[LAT-1];
  assign rsp_id    = r_id[LAT-1];
  assign rsp_data  = w_p[LAT-1];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a queue-of-entries model with per-entry age.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 16;
  localparam int R    = 8;
  localparam int PREC = 16;
  localparam int LAT  = 2;
  localparam int IDW  = 2;
  localparam int BW   = R + PREC;
  localparam int PW   = N + R + PREC;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*N-1:0]  req_a;
  logic [NREQ*BW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [PW-1:0]      rsp_data;
  logic               busy;

  mul_share_arbiter #(.NREQ(NREQ), .N(N), .R(R), .PRECISION(PREC), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [PW-1:0] prod;
    int          age;
  } ent_t;

  ent_t            mq[$];
  int              m_ptr;
  int              acc_log[$];
  int              rsp_log[$];
  int              n_cmp;
  int              n_err;
  logic [NREQ-1:0] acc_obs;
  logic [NREQ-1:0] obs_ready;
  logic            obs_rv;
  logic            obs_busy;
  logic [IDW-1:0]  obs_id;
  logic [PW-1:0]   obs_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model after the rising edge.
  task automatic step();
    int              gid;
    bit              exp_rv;
    bit              exp_stall;
    logic [NREQ-1:0] exp_ready;
    logic [PW-1:0]   prod;
    @(negedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0;
    end
    exp_rv    = (mq.size() > 0) && (mq[0].age == LAT-1);
    exp_stall = exp_rv && !rsp_ready;
    gid = -1;
    if (rst_n && !exp_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    exp_ready = '0;
    if (gid >= 0) exp_ready[gid] = 1'b1;
    prod = '0;
    if (gid >= 0) prod = PW'(req_a[gid*N +: N]) * PW'(req_b[gid*BW +: BW]);

    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check_eq("busy", 64'(busy), 64'(mq.size() > 0));
    if (exp_rv) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(mq[0].id));
      check_eq("rsp_data", 64'(rsp_data), 64'(mq[0].prod));
    end

    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_busy  = busy;
    obs_id    = rsp_id;
    obs_data  = rsp_data;
    acc_obs   = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) if (acc_obs[i]) acc_log.push_back(i);
    if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));

    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0;
    end else if (!exp_stall) begin
      if (exp_rv && rsp_ready) void'(mq.pop_front());
      foreach (mq[j]) mq[j].age++;
      if (gid >= 0) begin
        mq.push_back('{id: gid, prod: prod, age: 0});
        m_ptr = (gid + 1) % NREQ;
      end
    end
  endtask

  // Requesters still waiting keep their operands; idle ones may raise a fresh request.
  task automatic drive_keep(input int pv, input int pr);
    for (int i = 0; i < NREQ; i++) begin
      if (!(req_valid[i] && !acc_obs[i])) begin
        req_valid[i] = ($urandom_range(99) < pv);
        case ($urandom_range(7))
          0: begin req_a[i*N +: N] = 16'hFFFF; req_b[i*BW +: BW] = 24'hFFFFFF; end
          1: begin req_a[i*N +: N] = 16'h0000; req_b[i*BW +: BW] = BW'($urandom); end
          default: begin req_a[i*N +: N] = N'($urandom); req_b[i*BW +: BW] = BW'($urandom); end
        endcase
      end
    end
    rsp_ready = ($urandom_range(99) < pr);
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (!busy && req_valid == '0) break;
      drive_keep(0, 100);
      step();
    end
    check_eq("drained", 64'(busy | (|req_valid)), 64'(0));
  endtask

  // Requester obligation: a pending request keeps valid and operands stable.
  logic [NREQ-1:0]    p_pend;
  logic [NREQ*N-1:0]  p_a;
  logic [NREQ*BW-1:0] p_b;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (p_pend[i])
          assert (req_valid[i] && req_a[i*N +: N] == p_a[i*N +: N] && req_b[i*BW +: BW] == p_b[i*BW +: BW])
          else $error("requester %0d changed a pending request", i);
      end
    end
    p_pend <= rst_n ? (req_valid & ~req_ready) : '0;
    p_a    <= req_a;
    p_b    <= req_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0]  held_data;
    logic [IDW-1:0] held_id;
    int             nrsp;
    n_cmp = 0; n_err = 0; m_ptr = 0; acc_obs = '0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '1;
    req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N]   = N'(16'h0101 * (i + 1));
      req_b[i*BW +: BW] = BW'(24'h010203 * (i + 2));
    end

    step();
    step();
    check_eq("rst_ready", 64'(obs_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(obs_rv), 64'(0));
    check_eq("rst_busy", 64'(obs_busy), 64'(0));
    check_eq("rst_rsp_id", 64'(obs_id), 64'(0));
    check_eq("rst_rsp_data", 64'(obs_data), 64'(0));

    acc_log.delete(); rsp_log.delete();
    rst_n = 1'b1;
    step();
    check_eq("first_grant", 64'(obs_ready), 64'(4'b0001));
    for (int c = 0; c < 5; c++) begin
      drive_keep(100, 100);
      step();
    end
    check_eq("t3_ngrant", 64'(acc_log.size()), 64'(6));
    for (int k = 0; k < 6 && k < acc_log.size(); k++)
      check_eq($sformatf("t3_grant%0d", k), 64'(acc_log[k]), 64'(k % NREQ));
    check_eq("t3_nrsp", 64'(rsp_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < rsp_log.size(); k++)
      check_eq($sformatf("t3_rsp%0d", k), 64'(rsp_log[k]), 64'(k));

    drive_keep(100, 0);
    step();
    held_data = obs_data;
    held_id   = obs_id;
    check_eq("t4_stalled", 64'(obs_rv), 64'(1));
    for (int c = 0; c < 2; c++) begin
      drive_keep(100, 0);
      step();
      check_eq("t4_hold_data", 64'(obs_data), 64'(held_data));
      check_eq("t4_hold_id", 64'(obs_id), 64'(held_id));
      check_eq("t4_ready0", 64'(obs_ready), 64'(0));
    end
    for (int c = 0; c < 4; c++) begin
      drive_keep(100, 100);
      step();
    end
    drain();

    req_valid = 4'b0010;
    req_a[1*N +: N]   = 16'h0003;
    req_b[1*BW +: BW] = 24'h018000;
    rsp_ready = 1'b1;
    step();
    check_eq("t2_accept", 64'(obs_ready), 64'(4'b0010));
    req_valid = '0;
    step();
    check_eq("t2_k1_valid", 64'(obs_rv), 64'(0));
    step();
    check_eq("t2_valid", 64'(obs_rv), 64'(1));
    check_eq("t2_id", 64'(obs_id), 64'(1));
    check_eq("t2_data", 64'(obs_data), 64'h00_0004_8000);
    step();
    check_eq("t2_busy_after", 64'(obs_busy), 64'(0));

    req_valid = 4'b0101;
    req_a[0*N +: N] = 16'hFFFF; req_b[0*BW +: BW] = 24'hFFFFFF;
    req_a[2*N +: N] = 16'h0000; req_b[2*BW +: BW] = 24'hFFFFFF;
    rsp_log.delete();
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      req_valid = req_valid & ~acc_obs;
      if (obs_rv && rsp_ready) begin
        if (nrsp == 0) check_eq("t5_zero", 64'(obs_data), 64'(0));
        if (nrsp == 1) check_eq("t5_max", 64'(obs_data), 64'hFF_FEFF_0001);
        nrsp++;
      end
    end
    check_eq("t5_nrsp", 64'(nrsp), 64'(2));

    req_valid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      step();
      req_valid = req_valid & ~acc_obs;
    end
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    step();
    check_eq("t6_rsp_valid", 64'(obs_rv), 64'(0));
    check_eq("t6_busy", 64'(obs_busy), 64'(0));
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    rsp_log.delete();
    for (int c = 0; c < 4; c++) step();
    check_eq("t6_no_stale", 64'(rsp_log.size()), 64'(0));
    req_valid = '1;
    step();
    check_eq("t6_ptr0", 64'(obs_ready), 64'(4'b0001));

    for (int c = 0; c < 3000; c++) begin
      drive_keep(60, 70);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined fixed-point multiplier among NREQ requesters in the pixel-scaling datapath, for example the per-channel coordinate and weight scalers.
- Computes `a * b`, where `a` is an N-bit unsigned integer and `b` is unsigned fixed-point with R integer bits and PRECISION fraction bits.
- Returns the full-width product, unrounded and untruncated, tagged with the requester ID.
- Arbitration is round-robin. Issue rate is one product per cycle. The output side has backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 16, width of multiplicand a
- R, 8, integer bits of b
- PRECISION, 16, fraction bits of b
- LAT, 2, multiplier pipeline depth in cycles (1..4)
- Derived constants: IDW = clog2(NREQ); PW = N+R+PRECISION (product width); BW = R+PRECISION.

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_ready  out  NREQ  bit i: requester i's operands are accepted this cycle
- req_a  in  NREQ*N  packed multiplicands; requester i uses slice [i*N +: N]
- req_b  in  NREQ*BW  packed fixed-point multipliers; requester i uses slice [i*BW +: BW]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_data  out  PW  product a*b, with PRECISION fraction bits
- busy  out  1  at least one pipeline stage holds a valid entry

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchronizer):
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - All pipeline valid bits and payloads are 0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst_n=0.
- Reset asserted mid-operation discards all in-flight products; no response is emitted for them.
- Stall is defined as stall = rsp_valid & ~rsp_ready.
  - While stalled, every pipeline stage holds, including rsp_*.
  - While stalled, req_ready=0 on all bits.
- Arbitration is combinational:
  - Search from ptr upward with wrap-around.
  - The first i with req_valid[i]=1 gets grant[i].
  - req_ready = grant & {NREQ{~stall}}.
  - At most one req_ready bit is high in any cycle.
- Acceptance happens when req_valid[i] & req_ready[i] at a rising edge.
  - The operands, ID and a valid bit enter stage 1.
  - ptr updates to (i+1) mod NREQ.
  - If nothing is accepted, ptr is unchanged.
- Requester obligation: once req_valid is high, a, b and valid stay stable until req_ready. The bench checks this with an assertion.
- Latency: an entry accepted at edge k appears on rsp_* after edge k+LAT-1, i.e. visible in cycle k+LAT.
  - The delay is extended by exactly the number of stalled cycles in between.
- rsp_valid drops after a handshake edge (rsp_valid & rsp_ready) unless the next stage carries a valid entry.
- Throughput is one result per cycle with rsp_ready held high.
- Pipeline construction:
  - Stage 1 registers operands and ID.
  - The product is formed in stage 1 (for LAT=1) or between stage 1 and stage 2.
  - The remaining stages are plain delay registers.
  - Bubbles (valid=0) propagate as bubbles.
  - Data/ID registers hold when their stage is invalid; only valid bits are reset.
- Arithmetic: the product is unsigned, full width PW, and cannot overflow. No rounding, no saturation.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,..,NREQ-1,0 with no requester skipped.
- busy = OR of all stage valid bits, including the output stage.
- Simultaneous events:
  - An acceptance and a response handshake on the same edge are both honoured.
  - A requester may deassert req_valid only after acceptance.

Test Plan (NREQ=4, N=16, R=8, PRECISION=16, LAT=2):
1. Hold rst_n=0 with all req_valid=1 → req_ready=0000, rsp_valid=0, busy=0. Release reset → first grant is requester 0.
2. Requester 1 only, a=0x0003, b=0x018000 (1.5), rsp_ready=1 → accepted at edge k. rsp_valid=1, rsp_id=1, rsp_data=0x00_0004_8000 in cycle k+2. busy falls after the response.
3. All four valid continuously, rsp_ready=1, distinct operands → grants 0,1,2,3,0,1 on consecutive cycles. Responses arrive in the same order, back-to-back, with correct products.
4. Same as 3, but rsp_ready=0 for 3 cycles while rsp_valid=1 → rsp_data/rsp_id held constant and req_ready=0000 throughout. On release the sequence resumes with no loss or duplication.
5. a=0xFFFF, b=0xFFFFFF → rsp_data=0xFF_FEFF_0001. Also a=0, b=0xFFFFFF → rsp_data=0.
6. Pull rst_n low with 2 entries in flight → rsp_valid=0 and busy=0 immediately; no stale response appears after reset releases. ptr restarts at 0.
